// File: rtl/delay_timer_pkg.sv
// delay_timer_pkg: shared types and helpers for the multi-channel delay timer
package delay_timer_pkg;

    typedef enum logic [1:0] {DLY_ON, DLY_OFF, ONESHOT, RETRIG} mode_e;

    typedef enum logic [1:0] {IDLE, ARM, FIRE, PULSE} state_e;

    // Output is asserted (driven low) while firing or pulsing
    function automatic logic out_active(input state_e s);
        return (s == FIRE) || (s == PULSE);
    endfunction

endpackage

// File: rtl/delay_timer_ch.sv
// delay_timer_ch: one timer channel -- edge detect, mode FSM and down-counter on the shared tick
module delay_timer_ch
    import delay_timer_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic         trig,
    input  logic [1:0]   mode,
    input  logic [W-1:0] weight,
    output logic         delay_out_n,
    output logic         busy
);

    state_e       state_q, state_d;
    mode_e        mode_q, mode_d;
    mode_e        live_mode;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] n_q, n_d;
    logic         trig_q, trig_d;
    logic         out_n_q, out_n_d;
    logic         busy_q, busy_d;
    logic         rise, expiry, start;

    // Next-state logic; mode and weight are captured only on leaving IDLE
    always_comb begin
        live_mode = mode_e'(mode);
        trig_d    = trig;
        rise      = trig & ~trig_q;
        expiry    = tick && (cnt_q == W'(1));
        start     = (live_mode == ONESHOT || live_mode == RETRIG) ? rise : trig;
        state_d   = state_q;
        mode_d    = mode_q;
        n_d       = n_q;
        cnt_d     = ((state_q == ARM || state_q == PULSE) && tick && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
        case (state_q)
            IDLE: begin
                if (start && weight != '0) begin
                    mode_d  = live_mode;
                    n_d     = weight;
                    cnt_d   = weight;
                    state_d = (live_mode == DLY_ON) ? ARM : (live_mode == DLY_OFF) ? FIRE : PULSE;
                end
            end
            ARM: begin
                if (!trig) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (expiry) begin
                    state_d = FIRE;
                end
            end
            FIRE: begin
                if (!trig) begin
                    state_d = (mode_q == DLY_OFF) ? PULSE : IDLE;
                    cnt_d   = (mode_q == DLY_OFF) ? n_q : '0;
                end
            end
            PULSE: begin
                if (mode_q == DLY_OFF && trig) begin
                    state_d = FIRE;
                end else if (mode_q == RETRIG && rise) begin
                    cnt_d = n_q;
                end else if (expiry) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
        out_n_d = ~out_active(state_d);
        busy_d  = (state_d != IDLE);
    end

    // State, counter and registered outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= DLY_ON;
            cnt_q   <= '0;
            n_q     <= '0;
            trig_q  <= 1'b0;
            out_n_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            trig_q  <= trig_d;
            out_n_q <= out_n_d;
            busy_q  <= busy_d;
        end
    end

    assign delay_out_n = out_n_q;
    assign busy        = busy_q;

endmodule

// File: rtl/delay_timer_mc.sv
// delay_timer_mc: multi-channel programmable delay timer with shared prescaler.
// Define DELAY_TIMER_SYNC_EN to insert a 2-flop synchroniser on every trigger input.
module delay_timer_mc
    import delay_timer_pkg::*;
#(
    parameter int NUM_CH           = 4,
    parameter int WEIGHT_BIT_WIDTH = 8,
    parameter int PRESCALE_W       = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_CH-1:0]                    trigger_in,
    input  logic [2*NUM_CH-1:0]                  mode,
    input  logic [NUM_CH*WEIGHT_BIT_WIDTH-1:0]   weighted_bits,
    input  logic [PRESCALE_W-1:0]                prescale_div,
    output logic [NUM_CH-1:0]                    delay_out_n,
    output logic [NUM_CH-1:0]                    busy
);

    logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
    logic                  tick;
    logic [NUM_CH-1:0]     trig;

    // Free-running prescaler: tick on reaching the divisor, then wrap
    always_comb begin
        tick        = (presc_cnt_q == prescale_div);
        presc_cnt_d = tick ? '0 : presc_cnt_q + PRESCALE_W'(1);
    end

    // Prescaler register
    always_ff @(posedge clk) begin
        if (!rst_n) presc_cnt_q <= '0;
        else        presc_cnt_q <= presc_cnt_d;
    end

`ifdef DELAY_TIMER_SYNC_EN
    logic [NUM_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

    // Two-stage synchroniser chain for asynchronous triggers
    always_comb begin
        sync1_d = trigger_in;
        sync2_d = sync1_q;
    end

    // Synchroniser flops, cleared on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign trig = sync2_q;
`else
    assign trig = trigger_in;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        delay_timer_ch #(
            .W(WEIGHT_BIT_WIDTH)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick       (tick),
            .trig       (trig[c]),
            .mode       (mode[2*c +: 2]),
            .weight     (weighted_bits[c*WEIGHT_BIT_WIDTH +: WEIGHT_BIT_WIDTH]),
            .delay_out_n(delay_out_n[c]),
            .busy       (busy[c])
        );
    end

endmodule

// File: tb/tb_delay_timer_mc.sv
// tb_delay_timer_mc: directed self-checking bench for delay_timer_mc (honours DELAY_TIMER_SYNC_EN)
module tb_delay_timer_mc;

`ifdef DELAY_TIMER_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  trigger_in;
    logic [7:0]  mode;
    logic [31:0] weighted_bits;
    logic [7:0]  prescale_div;
    logic [3:0]  delay_out_n;
    logic [3:0]  busy;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    delay_timer_mc #(
        .NUM_CH(4),
        .WEIGHT_BIT_WIDTH(8),
        .PRESCALE_W(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trigger_in   (trigger_in),
        .mode         (mode),
        .weighted_bits(weighted_bits),
        .prescale_div (prescale_div),
        .delay_out_n  (delay_out_n),
        .busy         (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic inr(input int i, input int a, input int b);
        return (i >= a) && (i <= b);
    endfunction

    task automatic do_reset();
        rst_n        = 1'b0;
        trigger_in   = '0;
        prescale_div = '0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        mode          = 8'b01_01_01_01;
        weighted_bits = {4{8'd10}};
        prescale_div  = '0;
        rst_n         = 1'b0;
        for (int i = 0; i < 5; i++) begin
            trigger_in = i[0] ? 4'hF : 4'h0;
            step();
            checks++;
            if (delay_out_n !== 4'hF) begin errors++; $display("FAIL reset_out cyc %0d: got %b want 1111", i, delay_out_n); end
            checks++;
            if (busy !== 4'h0) begin errors++; $display("FAIL reset_busy cyc %0d: got %b want 0000", i, busy); end
        end
        trigger_in = '0;
        rst_n      = 1'b1;
    endtask

    task automatic test_dly_on();
        mode          = 8'b00_00_00_00;
        weighted_bits = {4{8'd10}};
        do_reset();
        for (int i = 1; i <= 25; i++) begin
            trigger_in[0] = (i <= 15);
            if (i == 3) weighted_bits[7:0] = 8'd2;
            step();
            checks++;
            if (delay_out_n[0] !== !inr(i, 11+L, 15+L)) begin errors++; $display("FAIL dly_on_out cyc %0d: got %b want %b", i, delay_out_n[0], !inr(i, 11+L, 15+L)); end
            checks++;
            if (busy[0] !== inr(i, 1+L, 15+L)) begin errors++; $display("FAIL dly_on_busy cyc %0d: got %b want %b", i, busy[0], inr(i, 1+L, 15+L)); end
        end
        weighted_bits[7:0] = 8'd10;
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            trigger_in[0] = (i <= 5);
            step();
            checks++;
            if (delay_out_n[0] !== 1'b1) begin errors++; $display("FAIL dly_on_short_out cyc %0d: got %b want 1", i, delay_out_n[0]); end
            checks++;
            if (busy[0] !== inr(i, 1+L, 5+L)) begin errors++; $display("FAIL dly_on_short_busy cyc %0d: got %b want %b", i, busy[0], inr(i, 1+L, 5+L)); end
        end
    endtask

    task automatic test_dly_off();
        mode          = 8'b00_00_00_01;
        weighted_bits = {4{8'd10}};
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            trigger_in[0] = (i <= 20);
            step();
            checks++;
            if (delay_out_n[0] !== !inr(i, 1+L, 30+L)) begin errors++; $display("FAIL dly_off_out cyc %0d: got %b want %b", i, delay_out_n[0], !inr(i, 1+L, 30+L)); end
        end
        do_reset();
        for (int i = 1; i <= 50; i++) begin
            trigger_in[0] = (i <= 20) || (i >= 24 && i <= 30);
            step();
            checks++;
            if (delay_out_n[0] !== !inr(i, 1+L, 40+L)) begin errors++; $display("FAIL dly_off_reraise_out cyc %0d: got %b want %b", i, delay_out_n[0], !inr(i, 1+L, 40+L)); end
            checks++;
            if (busy[0] !== inr(i, 1+L, 40+L)) begin errors++; $display("FAIL dly_off_reraise_busy cyc %0d: got %b want %b", i, busy[0], inr(i, 1+L, 40+L)); end
        end
    endtask

    task automatic test_oneshot_retrig();
        logic t;
        mode          = 8'b00_00_11_10;
        weighted_bits = {4{8'd8}};
        do_reset();
        for (int i = 1; i <= 25; i++) begin
            t = (i == 1) || (i == 2) || (i == 5) || (i == 6);
            trigger_in[1:0] = {t, t};
            step();
            checks++;
            if (delay_out_n[0] !== !inr(i, 1+L, 8+L)) begin errors++; $display("FAIL oneshot_out cyc %0d: got %b want %b", i, delay_out_n[0], !inr(i, 1+L, 8+L)); end
            checks++;
            if (delay_out_n[1] !== !inr(i, 1+L, 12+L)) begin errors++; $display("FAIL retrig_out cyc %0d: got %b want %b", i, delay_out_n[1], !inr(i, 1+L, 12+L)); end
        end
    endtask

    task automatic test_prescale();
        int first;
        int d;
        mode          = 8'b00_00_00_00;
        weighted_bits = {4{8'd5}};
        do_reset();
        prescale_div = 8'd3;
        first        = -1;
        for (int i = 1; i <= 40; i++) begin
            trigger_in[0] = 1'b1;
            step();
            if (first < 0 && delay_out_n[0] === 1'b0) first = i;
        end
        d = first - (1 + L);
        checks++;
        if (first < 0 || d < 16 || d > 20) begin errors++; $display("FAIL prescale_delay: got %0d cycles (first=%0d) want 16..20", d, first); end
        checks++;
        if (delay_out_n[0] !== 1'b0) begin errors++; $display("FAIL prescale_hold: got %b want 0", delay_out_n[0]); end
        weighted_bits[7:0] = 8'd0;
        do_reset();
        prescale_div = 8'd3;
        for (int i = 1; i <= 20; i++) begin
            trigger_in[0] = 1'b1;
            step();
            checks++;
            if (busy[0] !== 1'b0 || delay_out_n[0] !== 1'b1) begin errors++; $display("FAIL zero_weight cyc %0d: got busy=%b out=%b want busy=0 out=1", i, busy[0], delay_out_n[0]); end
        end
        trigger_in = '0;
    endtask

    function automatic logic [3:0] exp_out(input int i);
        return {!inr(i, 1+L, 5+L), !inr(i, 1+L, 6+L), !inr(i, 1+L, 14+L), !inr(i, 4+L, 10+L)};
    endfunction

    function automatic logic [3:0] exp_busy(input int i);
        return {inr(i, 1+L, 5+L), inr(i, 1+L, 6+L), inr(i, 1+L, 14+L), inr(i, 1+L, 10+L)};
    endfunction

    task automatic test_multi();
        mode          = 8'b11_10_01_00;
        weighted_bits = {8'd5, 8'd6, 8'd4, 8'd3};
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            trigger_in = (i <= 10) ? 4'hF : 4'h0;
            step();
            checks++;
            if (delay_out_n !== exp_out(i)) begin errors++; $display("FAIL multi_out cyc %0d: got %b want %b", i, delay_out_n, exp_out(i)); end
            checks++;
            if (busy !== exp_busy(i)) begin errors++; $display("FAIL multi_busy cyc %0d: got %b want %b", i, busy, exp_busy(i)); end
        end
    endtask

    task automatic test_reset_mid();
        mode          = 8'b11_10_01_00;
        weighted_bits = {8'd5, 8'd6, 8'd4, 8'd3};
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            trigger_in = 4'hF;
            step();
        end
        checks++;
        if (delay_out_n !== exp_out(7)) begin errors++; $display("FAIL mid_pre_out: got %b want %b", delay_out_n, exp_out(7)); end
        rst_n = 1'b0;
        step();
        checks++;
        if (delay_out_n !== 4'hF) begin errors++; $display("FAIL mid_reset_out: got %b want 1111", delay_out_n); end
        checks++;
        if (busy !== 4'h0) begin errors++; $display("FAIL mid_reset_busy: got %b want 0000", busy); end
        trigger_in = '0;
        step();
        rst_n = 1'b1;
        repeat (4) step();
        checks++;
        if (delay_out_n !== 4'hF || busy !== 4'h0) begin errors++; $display("FAIL mid_after_out: got out=%b busy=%b want 1111/0000", delay_out_n, busy); end
    endtask

    initial begin
        rst_n         = 1'b0;
        trigger_in    = '0;
        mode          = '0;
        weighted_bits = '0;
        prescale_div  = '0;
        test_reset();
        test_dly_on();
        test_dly_off();
        test_oneshot_retrig();
        test_prescale();
        test_multi();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
